// File: rtl/cci_mpf_shim_vtp_pt_walker.sv
// rtl/cci_mpf_shim_vtp_pt_walker.sv - VTP TLB miss handler walking the hashed page table
module cci_mpf_shim_vtp_pt_walker #(
   parameter int VA_PAGE_BITS   = 27,
   parameter int PA_IDX_BITS    = 20,
   parameter int VA_IDX_BITS    = 10,
   parameter int LINE_IDX_BITS  = 14,
   parameter int MAX_WALK_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                lookupMiss,
   input  logic [2*VA_PAGE_BITS-1:0] lookupMissVA,
   output logic                      ptReadEn,
   output logic [LINE_IDX_BITS-1:0]  ptReadLineIdx,
   input  logic                      ptReadRdy,
   input  logic                      ptReadRspValid,
   input  logic [511:0]              ptReadRspData,
   output logic                      fillEn,
   output logic [VA_PAGE_BITS-1:0]   fillVA,
   output logic [PA_IDX_BITS-1:0]    fillPA,
   input  logic                      fillRdy,
   output logic                      walkBusy,
   output logic                      walkError,
   output logic [VA_PAGE_BITS-1:0]   walkErrorVA
);
   localparam int TAG_BITS   = VA_PAGE_BITS - VA_IDX_BITS;
   localparam int DEPTH_BITS = $clog2(MAX_WALK_DEPTH + 1);
   localparam int NUM_SLOTS  = 7;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, MATCH, FILL} t_state;

   t_state                   state, nextState;
   logic [1:0]               pendValid;
   logic [VA_PAGE_BITS-1:0]  pendVA [2];
   logic [VA_PAGE_BITS-1:0]  walkVA;
   logic [LINE_IDX_BITS-1:0] lineIdx;
   logic [DEPTH_BITS-1:0]    depth;
   logic [511:0]             lineData;
   logic [PA_IDX_BITS-1:0]   fillPAReg;
   logic                     rrPri;

   logic                     selPort;
   logic [VA_PAGE_BITS-1:0]  selVA;
   logic                     hit;
   logic [PA_IDX_BITS-1:0]   hitPA;
   logic [LINE_IDX_BITS-1:0] nextLine;
   logic                     canChain;
   logic                     unusedLineBits;

   assign ptReadEn      = (state == REQ);
   assign ptReadLineIdx = lineIdx;
   assign fillEn        = (state == FILL);
   assign fillVA        = walkVA;
   assign fillPA        = fillPAReg;
   assign walkBusy      = (state != IDLE);

   // Slot 7 carries only the chain pointer; the rest of the line is don't-care.
   assign nextLine       = lineData[7*64 +: LINE_IDX_BITS];
   assign canChain       = (nextLine != '0) && (depth < DEPTH_BITS'(MAX_WALK_DEPTH));
   assign unusedLineBits = ^lineData;

   assign selPort = !(pendValid[0] && (!rrPri || !pendValid[1]));
   assign selVA   = pendVA[selPort];

   // Scan high to low so the lowest-numbered matching slot wins.
   always_comb begin
      hit   = 1'b0;
      hitPA = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (lineData[s*64 + 63] &&
             (lineData[s*64 + PA_IDX_BITS +: TAG_BITS] == walkVA[VA_PAGE_BITS-1:VA_IDX_BITS])) begin
            hit   = 1'b1;
            hitPA = lineData[s*64 +: PA_IDX_BITS];
         end
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (|pendValid) nextState = REQ;
         REQ:     if (ptReadRdy) nextState = WAIT;
         WAIT:    if (ptReadRspValid) nextState = MATCH;
         MATCH:   nextState = hit ? FILL : (canChain ? REQ : IDLE);
         FILL:    if (fillRdy) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pendValid   <= '0;
         pendVA[0]   <= '0;
         pendVA[1]   <= '0;
         walkVA      <= '0;
         lineIdx     <= '0;
         depth       <= '0;
         lineData    <= '0;
         fillPAReg   <= '0;
         rrPri       <= 1'b0;
         walkError   <= 1'b0;
         walkErrorVA <= '0;
      end else begin
         // A miss for the VA already being walked would only duplicate work.
         for (int i = 0; i < 2; i++) begin
            if (lookupMiss[i] && !pendValid[i] &&
                !(walkBusy && (lookupMissVA[i*VA_PAGE_BITS +: VA_PAGE_BITS] == walkVA))) begin
               pendValid[i] <= 1'b1;
               pendVA[i]    <= lookupMissVA[i*VA_PAGE_BITS +: VA_PAGE_BITS];
            end
         end

         case (state)
            IDLE: begin
               if (|pendValid) begin
                  pendValid[selPort] <= 1'b0;
                  rrPri              <= ~rrPri;
                  walkVA             <= selVA;
                  lineIdx            <= LINE_IDX_BITS'(selVA[VA_IDX_BITS-1:0]);
                  depth              <= DEPTH_BITS'(1);
               end
            end
            WAIT: begin
               if (ptReadRspValid) lineData <= ptReadRspData;
            end
            MATCH: begin
               if (hit) begin
                  fillPAReg <= hitPA;
               end else if (canChain) begin
                  lineIdx <= nextLine;
                  depth   <= depth + DEPTH_BITS'(1);
               end else begin
                  walkError <= 1'b1;
                  if (!walkError) walkErrorVA <= walkVA;
               end
            end
            FILL: begin
               if (fillRdy) begin
                  for (int i = 0; i < 2; i++) begin
                     if (pendValid[i] && (pendVA[i] == walkVA)) pendValid[i] <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cci_mpf_shim_vtp_pt_walker.sv
// tb/tb_cci_mpf_shim_vtp_pt_walker.sv - scoreboard bench for the VTP page-table walker
module tb_cci_mpf_shim_vtp_pt_walker;
   localparam int VA_PAGE_BITS   = 27;
   localparam int PA_IDX_BITS    = 20;
   localparam int VA_IDX_BITS    = 10;
   localparam int LINE_IDX_BITS  = 14;
   localparam int MAX_WALK_DEPTH = 16;
   localparam int TAG_BITS       = VA_PAGE_BITS - VA_IDX_BITS;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [1:0]                lookupMiss;
   logic [2*VA_PAGE_BITS-1:0] lookupMissVA;
   logic                      ptReadEn;
   logic [LINE_IDX_BITS-1:0]  ptReadLineIdx;
   logic                      ptReadRdy;
   logic                      ptReadRspValid;
   logic [511:0]              ptReadRspData;
   logic                      fillEn;
   logic [VA_PAGE_BITS-1:0]   fillVA;
   logic [PA_IDX_BITS-1:0]    fillPA;
   logic                      fillRdy;
   logic                      walkBusy;
   logic                      walkError;
   logic [VA_PAGE_BITS-1:0]   walkErrorVA;

   cci_mpf_shim_vtp_pt_walker #(
      .VA_PAGE_BITS(VA_PAGE_BITS), .PA_IDX_BITS(PA_IDX_BITS), .VA_IDX_BITS(VA_IDX_BITS),
      .LINE_IDX_BITS(LINE_IDX_BITS), .MAX_WALK_DEPTH(MAX_WALK_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .lookupMiss(lookupMiss), .lookupMissVA(lookupMissVA),
      .ptReadEn(ptReadEn), .ptReadLineIdx(ptReadLineIdx), .ptReadRdy(ptReadRdy),
      .ptReadRspValid(ptReadRspValid), .ptReadRspData(ptReadRspData),
      .fillEn(fillEn), .fillVA(fillVA), .fillPA(fillPA), .fillRdy(fillRdy),
      .walkBusy(walkBusy), .walkError(walkError), .walkErrorVA(walkErrorVA)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int reqCount = 0;
   int fillCount = 0;
   int rspLatency = 2;
   logic [511:0] mem [int];
   logic [VA_PAGE_BITS+PA_IDX_BITS-1:0] fillQ [$];
   int reqLog [$];

   function automatic logic [63:0] mkEntry(input logic [TAG_BITS-1:0] tag,
                                           input logic [PA_IDX_BITS-1:0] pa, input logic v);
      logic [63:0] e;
      e = '0;
      e[63] = v;
      e[PA_IDX_BITS +: TAG_BITS] = tag;
      e[PA_IDX_BITS-1:0] = pa;
      return e;
   endfunction

   task automatic setSlot(input int line, input int slot, input logic [63:0] e);
      logic [511:0] l;
      l = mem.exists(line) ? mem[line] : '0;
      l[slot*64 +: 64] = e;
      mem[line] = l;
   endtask

   task automatic setNext(input int line, input logic [LINE_IDX_BITS-1:0] nxt);
      logic [511:0] l;
      l = mem.exists(line) ? mem[line] : '0;
      l[7*64 +: LINE_IDX_BITS] = nxt;
      mem[line] = l;
   endtask

   // Host memory model: one response rspLatency cycles after each read handshake.
   initial begin
      int idx;
      ptReadRspValid = 1'b0;
      ptReadRspData  = '0;
      forever begin
         @(negedge clk);
         if (ptReadEn && ptReadRdy && !reset) begin
            idx = int'(ptReadLineIdx);
            reqCount++;
            reqLog.push_back(idx);
            repeat (rspLatency) @(negedge clk);
            ptReadRspValid = 1'b1;
            ptReadRspData  = mem.exists(idx) ? mem[idx] : '0;
            @(negedge clk);
            ptReadRspValid = 1'b0;
            ptReadRspData  = '0;
         end
      end
   end

   // Fill scoreboard.
   initial begin
      logic [VA_PAGE_BITS+PA_IDX_BITS-1:0] exp;
      forever begin
         @(negedge clk);
         if (fillEn && fillRdy) begin
            fillCount++;
            checks++;
            if (fillQ.size() == 0) begin
               failures++;
               $display("FAIL fill_unexpected: got VA=%h PA=%h, expected no fill", fillVA, fillPA);
            end else begin
               exp = fillQ.pop_front();
               if ({fillVA, fillPA} !== exp)
               begin
                  failures++;
                  $display("FAIL fill_value: got VA=%h PA=%h, expected VA=%h PA=%h",
                           fillVA, fillPA, exp[PA_IDX_BITS +: VA_PAGE_BITS], exp[PA_IDX_BITS-1:0]);
               end
            end
         end
      end
   end

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1; lookupMiss = '0; lookupMissVA = '0; ptReadRdy = 1'b1; fillRdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic sendMiss(input logic [1:0] ports, input logic [VA_PAGE_BITS-1:0] va0,
                           input logic [VA_PAGE_BITS-1:0] va1);
      @(posedge clk); #1;
      lookupMiss = ports;
      lookupMissVA = {va1, va0};
      @(posedge clk); #1;
      lookupMiss = '0;
   endtask

   task automatic waitQuiet(input int budget, input string name);
      int idle = 0;
      int n = 0;
      while (idle < 4 && n < budget) begin
         @(negedge clk);
         n++;
         idle = walkBusy ? 0 : idle + 1;
      end
      checks++;
      if (idle < 4) begin
         failures++;
         $display("FAIL %s_timeout: walker busy after %0d cycles, expected idle", name, n);
      end
   endtask

   task automatic test_reset();
      doReset();
      @(negedge clk);
      checks++;
      if ({ptReadEn, fillEn, walkBusy, walkError} !== 4'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b, expected 0000", {ptReadEn, fillEn, walkBusy, walkError});
      end
      checks++;
      if ({ptReadLineIdx, fillVA, fillPA, walkErrorVA} !== '0) begin
         failures++;
         $display("FAIL reset_buses: got idx=%h va=%h pa=%h eva=%h, expected 0",
                  ptReadLineIdx, fillVA, fillPA, walkErrorVA);
      end
   endtask

   task automatic test_single_hit();
      int n, r0, f0;
      setSlot(32'h123, 2, mkEntry('0, 20'h0ABCD, 1'b1));
      r0 = reqCount; f0 = fillCount; reqLog.delete();
      fillQ.push_back({27'h0000123, 20'h0ABCD});
      @(posedge clk); #1;
      lookupMiss = 2'b01;
      lookupMissVA = {27'h0, 27'h0000123};
      @(posedge clk); #1;
      lookupMiss = '0;
      n = 1;
      @(negedge clk);
      while (!fillEn && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n != 4 + rspLatency) begin
         failures++;
         $display("FAIL hit_latency: got %0d cycles, expected %0d", n, 4 + rspLatency);
      end
      waitQuiet(100, "hit");
      checks++;
      if (reqCount - r0 != 1 || reqLog.size() != 1 || reqLog[0] != 'h123) begin
         failures++;
         $display("FAIL hit_reads: got %0d reads, expected 1 read of line 123", reqCount - r0);
      end
      checks++;
      if (fillCount - f0 != 1) begin
         failures++;
         $display("FAIL hit_fills: got %0d, expected 1", fillCount - f0);
      end
   endtask

   task automatic test_chain();
      int r0, f0;
      setSlot(32'h005, 0, mkEntry(17'h1001, 20'h11111, 1'b1));
      setSlot(32'h005, 3, mkEntry(17'h0FFF, 20'h22222, 1'b1));
      setNext(32'h005, 14'h200);
      setSlot(32'h200, 0, mkEntry(17'h1000, 20'h00077, 1'b1));
      setSlot(32'h200, 1, mkEntry(17'h1000, 20'h00099, 1'b1));
      r0 = reqCount; f0 = fillCount; reqLog.delete();
      fillQ.push_back({27'h0400005, 20'h00077});
      sendMiss(2'b01, 27'h0400005, 27'h0);
      waitQuiet(200, "chain");
      checks++;
      if (reqCount - r0 != 2 || reqLog.size() != 2 || reqLog[0] != 'h005 || reqLog[1] != 'h200) begin
         failures++;
         $display("FAIL chain_reads: got %0d reads, expected 2 reads of lines 005,200", reqCount - r0);
      end
      checks++;
      if (fillCount - f0 != 1) begin
         failures++;
         $display("FAIL chain_fills: got %0d, expected 1", fillCount - f0);
      end
   endtask

   task automatic test_back_to_back();
      int r0, f0;
      doReset();
      setSlot(32'h010, 0, mkEntry('0, 20'h00100, 1'b1));
      setSlot(32'h020, 0, mkEntry('0, 20'h00200, 1'b1));
      r0 = reqCount; f0 = fillCount; reqLog.delete();
      fillQ.push_back({27'h10, 20'h00100});
      fillQ.push_back({27'h20, 20'h00200});
      sendMiss(2'b11, 27'h10, 27'h20);
      waitQuiet(200, "dual");
      checks++;
      if (fillCount - f0 != 2 || reqLog.size() != 2 || reqLog[0] != 'h10 || reqLog[1] != 'h20) begin
         failures++;
         $display("FAIL dual_order: got %0d fills %0d reads, expected 2 fills, port 0 first",
                  fillCount - f0, reqLog.size());
      end
      r0 = reqCount; f0 = fillCount;
      fillQ.push_back({27'h10, 20'h00100});
      sendMiss(2'b11, 27'h10, 27'h10);
      waitQuiet(200, "dedup");
      checks++;
      if (fillCount - f0 != 1 || reqCount - r0 != 1) begin
         failures++;
         $display("FAIL dedup: got %0d fills %0d reads, expected 1 and 1", fillCount - f0, reqCount - r0);
      end
   endtask

   task automatic test_backpressure();
      int n, r0, f0;
      logic stable;
      setSlot(32'h055, 0, mkEntry('0, 20'h0BEEF, 1'b1));
      r0 = reqCount; f0 = fillCount;
      fillQ.push_back({27'h55, 20'h0BEEF});
      @(posedge clk); #1;
      ptReadRdy = 1'b0; fillRdy = 1'b0;
      sendMiss(2'b10, 27'h0, 27'h55);
      n = 0;
      @(negedge clk);
      while (!ptReadEn && n < 20) begin @(negedge clk); n++; end
      stable = ptReadEn;
      repeat (5) begin
         @(negedge clk);
         if (!ptReadEn || ptReadLineIdx !== 14'h055) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL read_hold: got en=%b idx=%h, expected en=1 idx=055 held", ptReadEn, ptReadLineIdx);
      end
      @(posedge clk); #1;
      ptReadRdy = 1'b1;
      n = 0;
      @(negedge clk);
      while (!fillEn && n < 40) begin @(negedge clk); n++; end
      stable = fillEn;
      repeat (3) begin
         @(negedge clk);
         if (!fillEn || fillVA !== 27'h55 || fillPA !== 20'h0BEEF) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL fill_hold: got en=%b va=%h pa=%h, expected en=1 va=55 pa=0beef held",
                  fillEn, fillVA, fillPA);
      end
      @(posedge clk); #1;
      fillRdy = 1'b1;
      waitQuiet(100, "bp");
      checks++;
      if (reqCount - r0 != 1 || fillCount - f0 != 1) begin
         failures++;
         $display("FAIL bp_handshakes: got %0d reads %0d fills, expected 1 and 1",
                  reqCount - r0, fillCount - f0);
      end
   endtask

   task automatic test_not_found();
      int f0;
      setSlot(32'h321, 0, mkEntry(17'h1, 20'h11111, 1'b1));
      setSlot(32'h321, 1, mkEntry('0, 20'h22222, 1'b0));
      f0 = fillCount;
      @(negedge clk);
      checks++;
      if (walkError !== 1'b0) begin
         failures++;
         $display("FAIL err_pre: got walkError=%b, expected 0", walkError);
      end
      sendMiss(2'b01, 27'h321, 27'h0);
      waitQuiet(100, "nf1");
      checks++;
      if (walkError !== 1'b1 || walkErrorVA !== 27'h321) begin
         failures++;
         $display("FAIL err_first: got err=%b va=%h, expected err=1 va=321", walkError, walkErrorVA);
      end
      sendMiss(2'b10, 27'h0, 27'h322);
      waitQuiet(100, "nf2");
      checks++;
      if (walkError !== 1'b1 || walkErrorVA !== 27'h321 || fillCount != f0) begin
         failures++;
         $display("FAIL err_sticky: got err=%b va=%h fills=%0d, expected err=1 va=321 fills=0",
                  walkError, walkErrorVA, fillCount - f0);
      end
   endtask

   task automatic test_loop_guard();
      int r0, f0;
      doReset();
      setNext(32'h3AB, 14'h3AB);
      r0 = reqCount; f0 = fillCount;
      sendMiss(2'b01, 27'h3AB, 27'h0);
      waitQuiet(400, "loop");
      checks++;
      if (reqCount - r0 != MAX_WALK_DEPTH || fillCount != f0) begin
         failures++;
         $display("FAIL loop_reads: got %0d reads %0d fills, expected %0d reads 0 fills",
                  reqCount - r0, fillCount - f0, MAX_WALK_DEPTH);
      end
      checks++;
      if (walkError !== 1'b1 || walkErrorVA !== 27'h3AB) begin
         failures++;
         $display("FAIL loop_error: got err=%b va=%h, expected err=1 va=3ab", walkError, walkErrorVA);
      end
   endtask

   task automatic test_reset_mid_walk();
      int n, f0;
      rspLatency = 6;
      f0 = fillCount;
      sendMiss(2'b01, 27'h123, 27'h0);
      n = 0;
      @(negedge clk);
      while (!(ptReadEn && ptReadRdy) && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (walkBusy !== 1'b1 || ptReadEn !== 1'b0) begin
         failures++;
         $display("FAIL wait_state: got busy=%b en=%b, expected busy=1 en=0", walkBusy, ptReadEn);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({ptReadEn, fillEn, walkBusy, walkError, ptReadLineIdx, fillVA, fillPA, walkErrorVA} !== '0) begin
         failures++;
         $display("FAIL reset_mid: got en=%b fill=%b busy=%b err=%b idx=%h, expected all 0",
                  ptReadEn, fillEn, walkBusy, walkError, ptReadLineIdx);
      end
      repeat (10) @(negedge clk);
      waitQuiet(50, "rst");
      checks++;
      if (fillCount != f0 || walkBusy !== 1'b0) begin
         failures++;
         $display("FAIL stale_rsp: got %0d fills busy=%b, expected 0 fills idle", fillCount - f0, walkBusy);
      end
      rspLatency = 2;
   endtask

   initial begin
      reset = 1'b1; lookupMiss = '0; lookupMissVA = '0; ptReadRdy = 1'b1; fillRdy = 1'b1;
      test_reset();
      test_single_hit();
      test_chain();
      test_back_to_back();
      test_backpressure();
      test_not_found();
      test_loop_guard();
      test_reset_mid_walk();
      checks++;
      if (fillQ.size() != 0) begin
         failures++;
         $display("FAIL fills_missing: got %0d pending expected fills, expected 0", fillQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
